// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants, state type and width helper for the BCD-to-binary converter
package bcd_pkg;

    localparam int         NIBBLE_W      = 4;
    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Smallest binary width able to hold 10^digits - 1.
    function automatic int min_bin_w(input int digits);
        longint p;
        int     w;
        p = 1;
        for (int i = 0; i < digits; i++) begin
            p = p * 10;
        end
        w = 0;
        while ((longint'(1) << w) < p) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_nibble_adj.sv
// rtl/bcd_nibble_adj.sv - reverse double-dabble digit correction: subtract 3 from a nibble >= 8
module bcd_nibble_adj (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    assign o_nib = i_nib[3] ? (i_nib - 4'd3) : i_nib;

endmodule

// File: rtl/bcd_to_bin.sv
// rtl/bcd_to_bin.sv - sequential BCD-to-binary converter; optional input range check under BCD_ERR_CHECK_EN
module bcd_to_bin
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [NIBBLE_W*DIGITS-1:0] bcd_in,
    output logic                       busy,
    output logic                       done,
`ifdef BCD_ERR_CHECK_EN
    output logic                       err,
`endif
    output logic [BIN_W-1:0]           bin_out
);

    localparam int BCD_W = NIBBLE_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    if (BIN_W < min_bin_w(DIGITS)) begin : g_bin_w_check
        $error("bcd_to_bin: BIN_W too small for DIGITS");
    end

    state_e           r_state;
    logic [BCD_W-1:0] r_bcd;
    logic [BIN_W-1:0] r_bin;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [BIN_W-1:0] r_bin_out;

    logic [BCD_W-1:0] w_bcd_sh;
    logic [BCD_W-1:0] w_bcd_adj;
    logic [BIN_W-1:0] w_bin_sh;

    // One iteration: shift {bcd, bin} right, then correct every shifted digit.
    assign w_bcd_sh = {1'b0, r_bcd[BCD_W-1:1]};
    assign w_bin_sh = {r_bcd[0], r_bin[BIN_W-1:1]};

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_nibble_adj u_adj (
            .i_nib (w_bcd_sh[NIBBLE_W*i +: NIBBLE_W]),
            .o_nib (w_bcd_adj[NIBBLE_W*i +: NIBBLE_W])
        );
    end

`ifdef BCD_ERR_CHECK_EN
    logic [DIGITS-1:0] w_bad_nib;
    logic              w_bad;
    logic              r_bad;
    logic              r_err;

    for (genvar i = 0; i < DIGITS; i++) begin : g_rng
        assign w_bad_nib[i] = (bcd_in[NIBBLE_W*i +: NIBBLE_W] > BCD_MAX_DIGIT);
    end
    assign w_bad = |w_bad_nib;
    assign err   = r_err;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_bcd     <= '0;
            r_bin     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bin_out <= '0;
`ifdef BCD_ERR_CHECK_EN
            r_bad     <= 1'b0;
            r_err     <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_bcd  <= bcd_in;
                        r_bin  <= '0;
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
`ifdef BCD_ERR_CHECK_EN
                        r_bad   <= w_bad;
                        r_state <= w_bad ? DONE : SHIFT;
`else
                        r_state <= SHIFT;
`endif
                    end
                end
                SHIFT: begin
                    r_bcd <= w_bcd_adj;
                    r_bin <= w_bin_sh;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_CNT) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_bin_out <= r_bin;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
`ifdef BCD_ERR_CHECK_EN
                    r_err     <= r_bad;
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign bin_out = r_bin_out;

endmodule
